// File: rtl/supersonic_pkg.sv
// Shared types and constants for the ultrasonic ranger controller.
package supersonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } state_e;

  localparam int unsigned TRIG_CYCLES_DEF  = 500;
  localparam int unsigned ECHO_TIMEOUT_DEF = 1_500_000;
  localparam int unsigned ECHO_MAX_DEF     = 1_900_000;

  // 3.4 um per 20 ns cycle, one-way, expressed as 17/5.
  localparam int unsigned SCALE_NUM = 17;
  localparam int unsigned SCALE_DEN = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous bit.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/supersonic_ranger.sv
// Trigger qualification, echo timing and distance conversion for an HC-SR04 ranger.
module supersonic_ranger
  import supersonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES  = TRIG_CYCLES_DEF,
  parameter int unsigned ECHO_TIMEOUT = ECHO_TIMEOUT_DEF,
  parameter int unsigned ECHO_MAX     = ECHO_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic        echo,
  output logic        valid,
  output logic        triggerSuc,
  output logic [31:0] distance
);

  state_e      state_q, state_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] echo_cnt_q, echo_cnt_d;
  logic        ovf_q, ovf_d;
  logic        suc_q, suc_d;
  logic        valid_q, valid_d;
  logic [31:0] distance_q, distance_d;
  logic        echo_s;
  logic [31:0] product;

  sync_2ff u_echo_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (echo),
    .q_o    (echo_s)
  );

  assign product = echo_cnt_q * SCALE_NUM;

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    wait_cnt_d = wait_cnt_q;
    echo_cnt_d = echo_cnt_q;
    ovf_d      = ovf_q;
    suc_d      = suc_q;
    valid_d    = 1'b0;
    distance_d = distance_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          trig_cnt_d = 32'd1;
          suc_d      = (TRIG_CYCLES <= 1);
          state_d    = TRIG;
        end
      end
      TRIG: begin
        if (trigger) begin
          if (trig_cnt_q < TRIG_CYCLES) trig_cnt_d = trig_cnt_q + 32'd1;
          if (trig_cnt_q + 32'd1 >= TRIG_CYCLES) suc_d = 1'b1;
        end else if (trig_cnt_q >= TRIG_CYCLES) begin
          wait_cnt_d = '0;
          state_d    = WAIT_ECHO;
        end else begin
          trig_cnt_d = '0;
          suc_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      WAIT_ECHO: begin
        if (echo_s) begin
          echo_cnt_d = 32'd1;
          ovf_d      = 1'b0;
          state_d    = MEASURE;
        end else if (wait_cnt_q >= ECHO_TIMEOUT - 1) begin
          trig_cnt_d = '0;
          suc_d      = 1'b0;
          state_d    = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      MEASURE: begin
        if (echo_s) begin
          echo_cnt_d = echo_cnt_q + 32'd1;
          if (echo_cnt_q + 32'd1 >= ECHO_MAX) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d    = 1'b1;
        distance_d = ovf_q ? '1 : product / SCALE_DEN;
        suc_d      = 1'b0;
        ovf_d      = 1'b0;
        trig_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      trig_cnt_q <= '0;
      wait_cnt_q <= '0;
      echo_cnt_q <= '0;
      ovf_q      <= 1'b0;
      suc_q      <= 1'b0;
      valid_q    <= 1'b0;
      distance_q <= '0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      echo_cnt_q <= echo_cnt_d;
      ovf_q      <= ovf_d;
      suc_q      <= suc_d;
      valid_q    <= valid_d;
      distance_q <= distance_d;
    end
  end

  assign valid      = valid_q;
  assign triggerSuc = suc_q;
  assign distance   = distance_q;

endmodule

// File: tb/tb_supersonic_ranger.sv
// Directed self-checking bench for supersonic_ranger.
module tb_supersonic_ranger;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic        echo;
  logic        valid;
  logic        triggerSuc;
  logic [31:0] distance;

  logic        trig2;
  logic        echo2;
  logic        valid2;
  logic        suc2;
  logic [31:0] dist2;

  int checks;
  int errors;
  int vcnt;
  int vcnt2;

  supersonic_ranger #(
    .TRIG_CYCLES  (500),
    .ECHO_TIMEOUT (3000),
    .ECHO_MAX     (1_900_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger    (trigger),
    .echo       (echo),
    .valid      (valid),
    .triggerSuc (triggerSuc),
    .distance   (distance)
  );

  // Small limits so the overflow path is reachable quickly.
  supersonic_ranger #(
    .TRIG_CYCLES  (4),
    .ECHO_TIMEOUT (50),
    .ECHO_MAX     (100)
  ) dut_ovf (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger    (trig2),
    .echo       (echo2),
    .valid      (valid2),
    .triggerSuc (suc2),
    .distance   (dist2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (valid) vcnt++;
    if (valid2) vcnt2++;
  endtask

  task automatic run_trigger(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  task automatic echo_pulse(input int n);
    echo = 1'b1;
    repeat (n) tick();
    echo = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #5;
    checks++;
    if ({valid, triggerSuc, distance} !== 34'd0) begin
      errors++;
      $display("FAIL reset_main: got v=%0b s=%0b d=%0d expected all 0", valid, triggerSuc, distance);
    end
    checks++;
    if ({valid2, suc2, dist2} !== 34'd0) begin
      errors++;
      $display("FAIL reset_ovf: got v=%0b s=%0b d=%0d expected all 0", valid2, suc2, dist2);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_normal_65535();
    bit seen_early;
    int v0;
    v0 = vcnt;
    seen_early = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 499; i++) begin
      tick();
      if (triggerSuc) seen_early = 1'b1;
    end
    checks++;
    if (seen_early !== 1'b0) begin
      errors++;
      $display("FAIL suc_early: got 1 expected 0 before 500 cycles");
    end
    tick();
    checks++;
    if (triggerSuc !== 1'b1) begin
      errors++;
      $display("FAIL suc_at_500: got %0b expected 1", triggerSuc);
    end
    trigger = 1'b0;
    echo_pulse(65535);
    repeat (3) tick();
    checks++;
    if ({valid, triggerSuc} !== 2'b01) begin
      errors++;
      $display("FAIL pre_valid: got v=%0b s=%0b expected v=0 s=1", valid, triggerSuc);
    end
    tick();
    checks++;
    if ({valid, triggerSuc} !== 2'b10) begin
      errors++;
      $display("FAIL valid_edge: got v=%0b s=%0b expected v=1 s=0", valid, triggerSuc);
    end
    checks++;
    if (distance !== 32'd222819) begin
      errors++;
      $display("FAIL dist_65535: got %0d expected 222819", distance);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: got %0b expected 0", valid);
    end
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL valid_count: got %0d expected 1", vcnt - v0);
    end
  endtask

  task automatic test_short_trigger();
    bit seen;
    int v0;
    v0 = vcnt;
    seen = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 499; i++) begin
      tick();
      if (triggerSuc) seen = 1'b1;
    end
    trigger = 1'b0;
    tick();
    if (triggerSuc) seen = 1'b1;
    echo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (triggerSuc) seen = 1'b1;
    end
    echo = 1'b0;
    repeat (10) tick();
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL short_suc: got 1 expected 0");
    end
    checks++;
    if (vcnt - v0 !== 0) begin
      errors++;
      $display("FAIL short_valid: got %0d pulses expected 0", vcnt - v0);
    end
    checks++;
    if (distance !== 32'd222819) begin
      errors++;
      $display("FAIL short_hold: got %0d expected 222819", distance);
    end
  endtask

  task automatic test_timeout();
    int v0;
    v0 = vcnt;
    run_trigger(500);
    tick();
    repeat (2999) tick();
    checks++;
    if (triggerSuc !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got %0b expected 1", triggerSuc);
    end
    tick();
    checks++;
    if (triggerSuc !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %0b expected 0", triggerSuc);
    end
    echo_pulse(10);
    repeat (10) tick();
    checks++;
    if (vcnt - v0 !== 0) begin
      errors++;
      $display("FAIL timeout_valid: got %0d pulses expected 0", vcnt - v0);
    end
  endtask

  task automatic test_overflow();
    int n;
    bit seen;
    int v0;
    v0 = vcnt2;
    seen = 1'b0;
    n = 0;
    trig2 = 1'b1;
    repeat (4) tick();
    trig2 = 1'b0;
    echo2 = 1'b1;
    while (!seen && n < 300) begin
      tick();
      n++;
      if (valid2) seen = 1'b1;
    end
    checks++;
    if (n !== 103) begin
      errors++;
      $display("FAIL ovf_latency: got %0d cycles expected 103", n);
    end
    checks++;
    if (dist2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL ovf_dist: got %h expected ffffffff", dist2);
    end
    repeat (20) tick();
    echo2 = 1'b0;
    repeat (5) tick();
    checks++;
    if (vcnt2 - v0 !== 1) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected 1", vcnt2 - v0);
    end
  endtask

  task automatic test_distances();
    int n_tab [4];
    int d_tab [4];
    bit seen;
    n_tab = '{1000, 5, 1, 3};
    d_tab = '{3400, 17, 3, 10};
    for (int k = 0; k < 4; k++) begin
      run_trigger(500);
      echo_pulse(n_tab[k]);
      wait_valid(seen);
      checks++;
      if (!seen || distance !== 32'(d_tab[k])) begin
        errors++;
        $display("FAIL dist_%0d: got valid=%0b d=%0d expected valid=1 d=%0d",
                 n_tab[k], seen, distance, d_tab[k]);
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_reset_mid_measure();
    int v0;
    run_trigger(500);
    echo = 1'b1;
    repeat (200) tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, triggerSuc, distance} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b s=%0b d=%0d expected all 0", valid, triggerSuc, distance);
    end
    echo = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = vcnt;
    repeat (20) tick();
    checks++;
    if (vcnt - v0 !== 0 || distance !== 32'd0) begin
      errors++;
      $display("FAIL post_reset: got %0d pulses d=%0d expected 0 pulses d=0", vcnt - v0, distance);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    vcnt    = 0;
    vcnt2   = 0;
    trigger = 1'b0;
    echo    = 1'b0;
    trig2   = 1'b0;
    echo2   = 1'b0;
    test_reset();
    test_normal_65535();
    repeat (5) tick();
    test_short_trigger();
    test_timeout();
    test_overflow();
    test_distances();
    test_reset_mid_measure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/supersonic_ranger.md
# supersonic_ranger

Measurement controller for an HC-SR04-style ultrasonic ranger, running on the 50 MHz system clock. It qualifies a host trigger pulse, times the sensor's echo pulse in clock cycles, and converts that time to a one-way distance in micrometres. It presents the result with a one-cycle `valid` strobe to downstream display and control logic.

## Interface
- `TRIG_CYCLES`, 500: minimum consecutive high cycles on `trigger` (10 µs at 50 MHz).
- `ECHO_TIMEOUT`, 1_500_000: cycles allowed in WAIT_ECHO for the echo rising edge (30 ms).
- `ECHO_MAX`, 1_900_000: maximum echo high time in cycles (38 ms).
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  host trigger request, synchronous to `clk`.
- `echo`  in  1  sensor echo line, asynchronous to `clk`.
- `valid`  out  1  one-cycle strobe; `distance` is fresh on this cycle.
- `triggerSuc`  out  1  high while an accepted trigger's measurement is in progress.
- `distance`  out  32  last result in µm; held until the next result.
- One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- `echo` passes through a 2-flop synchroniser before use. `trigger` is used directly.
- FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
- IDLE: on `trigger`=1, load trig_cnt=1 and go to TRIG.
- TRIG, while `trigger`=1: increment trig_cnt, saturating at TRIG_CYCLES. Set `triggerSuc` when trig_cnt reaches TRIG_CYCLES.
- TRIG, on `trigger`=0: if trig_cnt ≥ TRIG_CYCLES, go to WAIT_ECHO; otherwise drop `triggerSuc` and go to IDLE (short pulse rejected).
- Echo is ignored in IDLE and TRIG, including X/unknown values.
- WAIT_ECHO: count cycles. On synced echo=1, set echo_cnt=1 and go to MEASURE. At ECHO_TIMEOUT, go to IDLE with no `valid` and `triggerSuc` cleared.
- MEASURE: increment echo_cnt each cycle synced echo=1. On synced echo=0, go to DONE.
- MEASURE overflow: if echo_cnt reaches ECHO_MAX, go to DONE with an overflow flag set.
- DONE, normal: distance ← (echo_cnt × 17) / 5, truncating. This is 3.4 µm per 20 ns cycle at 340 m/s, one-way. Use a 32-bit unsigned product; the constant divide is combinational.
- DONE, overflow: distance ← 32'hFFFF_FFFF.
- DONE actions: pulse `valid` for one cycle, clear `triggerSuc`, return to IDLE.
- `trigger` activity outside IDLE/TRIG is ignored. A new measurement needs `trigger` observed in IDLE.

## Timing
- Reset values: `valid`=0, `triggerSuc`=0, `distance`=0, state=IDLE, counters=0.
- `triggerSuc` rises on the edge that samples trigger high for the TRIG_CYCLES-th consecutive cycle.
- echo_cnt equals the number of rising edges at which raw `echo` is high. The synchroniser delays the count but does not change it.
- `valid` rises 3 clock edges after the first edge that samples raw `echo` low: 2 synchroniser stages plus the DONE register.
- `distance` updates on the same edge that `valid` rises.
- Async reset at any point aborts the measurement immediately, with no `valid`.
- Echo already high on entry to WAIT_ECHO counts from the first WAIT_ECHO cycle.

## Structure
- Package `supersonic_pkg`: state enum and the default TRIG_CYCLES, ECHO_TIMEOUT and ECHO_MAX values, plus the constants 17 and 5 (scale numerator/denominator).
- Sub-module `sync_2ff`: 1-bit, 2-stage synchroniser with asynchronous active-low reset to 0, used for `echo`.

## Test plan
- Trigger high 500 cycles, then echo high 65535 cycles → `triggerSuc`=1 from cycle 500 until DONE; one `valid` pulse; distance=222819.
- Trigger high 499 cycles, then echo pulse → `triggerSuc` never set, no `valid`, distance keeps its prior value.
- Trigger 500 cycles, no echo for 1_500_000 cycles → return to IDLE, no `valid`, `triggerSuc` cleared.
- Trigger 500 cycles, echo high ≥ 1_900_000 cycles → `valid` pulse, distance=32'hFFFF_FFFF.
- Echo high 1000 cycles → distance=3400. A second trigger then gives echo 5 cycles → distance=17.
- Assert `rst_n`=0 mid-MEASURE → all outputs 0 asynchronously, no `valid` after release.
